// File: rtl/mux_n_reg_if.sv
// Channel-mux bus: N producer channels with per-channel valid/ready on one side,
// a single registered word with valid/ready toward the consumer on the other.
interface mux_n_reg_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
);
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          data_out;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_valid;
  logic                      out_ready;

  // Drives the channels and the consumer-side ready.
  modport master (
    output mode, sel, in_valid, data_in, out_ready,
    input  in_ready, data_out, out_sel, out_valid
  );

  // The mux itself.
  modport slave (
    input  mode, sel, in_valid, data_in, out_ready,
    output in_ready, data_out, out_sel, out_valid
  );
endinterface

// File: rtl/mux_n_reg.sv
// Registered N-to-1 channel mux: direct selection or round-robin over valid
// channels, with the chosen word held in an output register under valid/ready.
module mux_n_reg #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic       clk,
  input  logic       reset,
  mux_n_reg_if.slave bus
);

  // Selector space rounded up to a power of two so any sel value indexes safely.
  localparam int SPAN = 1 << SEL_W;

  if (CHANNELS < 2) begin : g_bad_channels
    $error("mux_n_reg: CHANNELS must be at least 2");
  end

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_cand;
  logic [SEL_W-1:0] cand;
  logic             grant_valid;
  logic             load;
  logic             capture;
  logic [SPAN-1:0]  valid_ext;
  logic [WIDTH-1:0] cand_word;

  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] sel_q;
  logic             valid_q;

  assign load = !valid_q || bus.out_ready;

  // Walk offsets from the far end back toward ptr+1 so the nearest valid
  // channel after ptr is the last one written and therefore wins.
  always_comb begin : rr_scan
    int idx;
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    rr_cand = ptr;
    idx     = 0;
    for (int off = CHANNELS; off >= 1; off--) begin
      idx = int'(ptr) + off;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (bus.in_valid[idx]) rr_cand = SEL_W'(idx);
    end
  end

  // Out-of-range selectors land on the zero-padded upper bits of valid_ext,
  // so they simply produce no grant.
  always_comb begin : grant_sel
    valid_ext                 = '0;
    valid_ext[CHANNELS-1:0]   = bus.in_valid;
    if (bus.mode) begin
      cand        = rr_cand;
      grant_valid = |bus.in_valid;
    end else begin
      cand        = bus.sel;
      grant_valid = valid_ext[bus.sel];
    end
  end

  assign capture = !reset && load && grant_valid;

  always_comb begin : ready_and_data
    bus.in_ready = '0;
    cand_word    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cand == SEL_W'(i)) begin
        bus.in_ready[i] = capture;
        cand_word       = bus.data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr     <= SEL_W'(CHANNELS - 1);
    end else if (load) begin
      if (grant_valid) begin
        data_q  <= cand_word;
        sel_q   <= cand;
        valid_q <= 1'b1;
        if (bus.mode) ptr <= cand;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data_out  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed bench for mux_n_reg: an 8-channel instance driven from a vector table
// plus hand sequences, and a 5-channel instance for out-of-range selectors.
module tb_mux_n_reg;

  logic clk;
  logic rst8;
  logic rst5;

  int checks = 0;
  int errors = 0;

  mux_n_reg_if #(.WIDTH(32), .CHANNELS(8)) b8 ();
  mux_n_reg_if #(.WIDTH(32), .CHANNELS(5)) b5 ();

  mux_n_reg #(.WIDTH(32), .CHANNELS(8)) u8 (
    .clk   (clk),
    .reset (rst8),
    .bus   (b8.slave)
  );

  mux_n_reg #(.WIDTH(32), .CHANNELS(5)) u5 (
    .clk   (clk),
    .reset (rst5),
    .bus   (b5.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        mode;
    logic [2:0]  sel;
    logic [7:0]  in_valid;
    logic        out_ready;
    logic [7:0]  exp_ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [2:0]  exp_sel;
  } vec_t;

  vec_t vecs[32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic v, input logic [31:0] d, input logic [2:0] s);
    check({tag, " out_valid"}, 64'(b8.out_valid), 64'(v));
    check({tag, " data_out"},  64'(b8.data_out),  64'(d));
    check({tag, " out_sel"},   64'(b8.out_sel),   64'(s));
  endtask

  task automatic check5(input string tag, input logic v, input logic [31:0] d, input logic [2:0] s);
    check({tag, " out_valid"}, 64'(b5.out_valid), 64'(v));
    check({tag, " data_out"},  64'(b5.data_out),  64'(d));
    check({tag, " out_sel"},   64'(b5.out_sel),   64'(s));
  endtask

  initial begin
    int n;
    int sk[8];
    sk = '{0, 1, 3, 4, 6, 7, 0, 1};

    // Vector table: direct sweep, 16 cycles of full round-robin, then with 2 and 5 idle.
    n = 0;
    for (int s = 0; s < 8; s++) begin
      vecs[n] = '{1'b0, 3'(s), 8'hFF, 1'b1, 8'(1 << s), 1'b1, 32'(32'hA0 + s), 3'(s)};
      n++;
    end
    for (int k = 0; k < 16; k++) begin
      vecs[n] = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'(1 << (k % 8)), 1'b1, 32'(32'hA0 + k % 8), 3'(k % 8)};
      n++;
    end
    for (int k = 0; k < 8; k++) begin
      vecs[n] = '{1'b1, 3'd0, 8'hDB, 1'b1, 8'(1 << sk[k]), 1'b1, 32'(32'hA0 + sk[k]), 3'(sk[k])};
      n++;
    end

    for (int i = 0; i < 8; i++) b8.data_in[i*32 +: 32] = 32'(32'hA0 + i);
    for (int i = 0; i < 5; i++) b5.data_in[i*32 +: 32] = 32'(32'hA0 + i);

    // ---------------- 8-channel: reset held two cycles under full load
    rst8 = 1'b1;
    rst5 = 1'b1;
    b8.mode = 1'b1; b8.sel = 3'd0; b8.in_valid = 8'hFF; b8.out_ready = 1'b1;
    b5.mode = 1'b0; b5.sel = 3'd2; b5.in_valid = 5'h1F; b5.out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("reset in_ready", 64'(b8.in_ready), 64'h0);
      edge_step();
      check8("reset", 1'b0, 32'h0, 3'd0);
    end
    rst8 = 1'b0;

    // ---------------- vector table
    for (int v = 0; v < 32; v++) begin
      b8.mode      = vecs[v].mode;
      b8.sel       = vecs[v].sel;
      b8.in_valid  = vecs[v].in_valid;
      b8.out_ready = vecs[v].out_ready;
      #1;
      check($sformatf("vec%0d in_ready", v), 64'(b8.in_ready), 64'(vecs[v].exp_ready));
      edge_step();
      check8($sformatf("vec%0d", v), vecs[v].exp_valid, vecs[v].exp_data, vecs[v].exp_sel);
    end

    // ---------------- back-pressure: hold 0x1234 from channel 3
    b8.mode = 1'b0; b8.sel = 3'd3; b8.in_valid = 8'hFF; b8.out_ready = 1'b1;
    b8.data_in[3*32 +: 32] = 32'h1234;
    #1;
    check("bp load in_ready", 64'(b8.in_ready), 64'h08);
    edge_step();
    check8("bp load", 1'b1, 32'h1234, 3'd3);
    b8.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b8.sel = 3'(k + 4);
      b8.data_in[3*32 +: 32] = 32'(32'hDEAD0000 + k);
      #1;
      check($sformatf("bp hold%0d in_ready", k), 64'(b8.in_ready), 64'h0);
      edge_step();
      check8($sformatf("bp hold%0d", k), 1'b1, 32'h1234, 3'd3);
    end
    b8.data_in[3*32 +: 32] = 32'hA3;
    b8.sel = 3'd5;
    b8.out_ready = 1'b1;
    #1;
    check("bp release in_ready", 64'(b8.in_ready), 64'h20);
    edge_step();
    check8("bp release", 1'b1, 32'hA5, 3'd5);

    // ---------------- reset mid-stream while holding channel 4 (ptr currently 1)
    b8.mode = 1'b1; b8.in_valid = 8'h10; b8.out_ready = 1'b1;
    #1;
    check("mid grab4 in_ready", 64'(b8.in_ready), 64'h10);
    edge_step();
    check8("mid grab4", 1'b1, 32'hA4, 3'd4);
    b8.in_valid = 8'hFF; b8.out_ready = 1'b0;
    #1;
    check("mid stall in_ready", 64'(b8.in_ready), 64'h0);
    edge_step();
    check8("mid stall", 1'b1, 32'hA4, 3'd4);
    rst8 = 1'b1;
    #1;
    check("mid reset in_ready", 64'(b8.in_ready), 64'h0);
    edge_step();
    check8("mid reset", 1'b0, 32'h0, 3'd0);
    rst8 = 1'b0;
    b8.out_ready = 1'b1;
    #1;
    check("post reset in_ready", 64'(b8.in_ready), 64'h01);
    edge_step();
    check8("post reset", 1'b1, 32'hA0, 3'd0);
    b8.in_valid = 8'h00;
    #1;
    check("drain in_ready", 64'(b8.in_ready), 64'h0);
    edge_step();
    check8("drain", 1'b0, 32'hA0, 3'd0);

    // ---------------- 5-channel: out-of-range sel and 4->0 wrap
    edge_step();
    check5("r5 reset", 1'b0, 32'h0, 3'd0);
    rst5 = 1'b0;
    #1;
    check("r5 sel2 in_ready", 64'(b5.in_ready), 64'h04);
    edge_step();
    check5("r5 sel2", 1'b1, 32'hA2, 3'd2);
    b5.sel = 3'd6;
    #1;
    check("r5 sel6 in_ready", 64'(b5.in_ready), 64'h0);
    edge_step();
    check5("r5 sel6", 1'b0, 32'hA2, 3'd2);
    b5.sel = 3'd5;
    #1;
    check("r5 sel5 in_ready", 64'(b5.in_ready), 64'h0);
    edge_step();
    check5("r5 sel5", 1'b0, 32'hA2, 3'd2);
    b5.mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("r5 rr%0d in_ready", k), 64'(b5.in_ready), 64'(1 << (k % 5)));
      edge_step();
      check5($sformatf("r5 rr%0d", k), 1'b1, 32'(32'hA0 + k % 5), 3'(k % 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
